qtree_stream_player: RTL and testbench

//  Synthesizable multi-input AXI-Stream stimulus player and result catcher for QTree accelerator benches and on-board self-test.

---
 rtl/qtree_stream_player.sv | 106 ++++++++++
 tb/tb_qtree_stream_player.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/qtree_stream_player.sv
// qtree_stream_player: buffers load words, replays them as AXI-Stream segments, then catches the first valid result.
module qtree_stream_player #(
    parameter int unsigned DATA_W   = 67,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned MAX_SEGS = 4,
    parameter int unsigned RES_W    = 67,
    parameter int unsigned TIMEOUT  = 2**20
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              start,
    output logic              m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    input  logic              m_tready,
    input  logic [RES_W-1:0]  res_data,
    output logic              done,
    output logic [RES_W-1:0]  result,
    output logic [31:0]       cycles,
    output logic [2:0]        err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {LOAD, PLAY, WAIT_RES, FIN} state_t;
    state_t state, state_n;
    logic [DATA_W:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] seg_cnt, tcnt;
    logic armed, cnt_on, full, load_wr, go, active, hs, last_hs, capture, timeout;
    assign full     = wr_ptr == (AW+1)'(DEPTH);
    assign ld_ready = state == LOAD && armed && !full;
    assign load_wr  = ld_valid && ld_ready;
    assign go       = state == LOAD && start && wr_ptr != '0;
    assign active   = state == PLAY || state == WAIT_RES;
    assign hs       = m_tvalid && m_tready;
    assign last_hs  = hs && rd_ptr == wr_ptr;
    assign capture  = active && res_data[0];
    assign timeout  = state == WAIT_RES && tcnt == TIMEOUT - 1;
    always_ff @(posedge aclk) state <= !aresetn ? LOAD : state_n;
    always_comb begin
        state_n = state;
        unique case (state)
            LOAD:     state_n = go ? PLAY : LOAD;
            PLAY:     state_n = capture ? FIN : last_hs ? WAIT_RES : PLAY;
            WAIT_RES: state_n = capture || timeout ? FIN : WAIT_RES;
            default:  state_n = FIN;
        endcase
    end
    always_ff @(posedge aclk)
        if (load_wr) mem[wr_ptr[AW-1:0]] <= {ld_last, ld_data};
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seg_cnt  <= '0;
            tcnt     <= '0;
            armed    <= 1'b0;
            cnt_on   <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cycles   <= '0;
            err      <= '0;
        end else begin
            armed <= 1'b1;
            if (load_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (ld_last) seg_cnt <= seg_cnt + 1;
                if (ld_last && seg_cnt >= MAX_SEGS) err[1] <= 1'b1;
            end
            if (state == LOAD && ld_valid && full) err[0] <= 1'b1;
            // Output register doubles as the RAM read register: refill whenever empty or consumed.
            if (state == PLAY && !capture) begin
                if (!m_tvalid || m_tready) begin
                    if (rd_ptr != wr_ptr) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= mem[rd_ptr[AW-1:0]][DATA_W-1:0];
                        m_tlast  <= mem[rd_ptr[AW-1:0]][DATA_W] || rd_ptr == wr_ptr - 1'b1;
                        rd_ptr   <= rd_ptr + 1'b1;
                    end else begin
                        m_tvalid <= 1'b0;
                    end
                end
            end else begin
                m_tvalid <= 1'b0;
            end
            if (active && (m_tvalid || cnt_on)) begin
                cnt_on <= 1'b1;
                cycles <= cycles + 32'(cycles != '1);
            end
            if (state == WAIT_RES) tcnt <= tcnt + 1;
            if (capture) begin
                result <= res_data;
                done   <= 1'b1;
            end else if (timeout) begin
                err[2] <= 1'b1;
                done   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qtree_stream_player.sv
// tb_qtree_stream_player: random segment loads replayed against a queue scoreboard of expected beats.
module tb_qtree_stream_player;
    localparam int DW = 67, RW = 67, DEP = 16, TO = 16;
    logic aclk = 1'b0, aresetn = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, start = 1'b0, m_tready = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic [RW-1:0] res_data = '0;
    logic ld_ready, m_tvalid, m_tlast, done;
    logic [DW-1:0] m_tdata;
    logic [RW-1:0] result;
    logic [31:0] cycles;
    logic [2:0] err;
    int n_chk = 0, n_err = 0;
    logic [DW:0] q[$];

    qtree_stream_player #(.DATA_W(DW), .DEPTH(DEP), .MAX_SEGS(4), .RES_W(RW), .TIMEOUT(TO)) dut (
        .aclk(aclk), .aresetn(aresetn), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .start(start), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tready(m_tready), .res_data(res_data), .done(done), .result(result), .cycles(cycles), .err(err)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [66:0] rnd();
        return 67'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0; ld_valid = 1'b0; start = 1'b0; res_data = '0; m_tready = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("rst_outs", {ld_ready, m_tvalid, m_tlast, done, err}, '0);
        check("rst_vals", {m_tdata, result, cycles}, '0);
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("rst_ld_ready", ld_ready, 1'b1);
        q.delete();
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic l);
        @(negedge aclk);
        ld_valid = 1'b1; ld_data = d; ld_last = l;
        if (ld_ready) q.push_back({l, d});
        @(posedge aclk);
        #1 ld_valid = 1'b0;
    endtask

    task automatic load_seg(input int len);
        for (int i = 0; i < len; i++) load_word(rnd(), i == len - 1);
    endtask

    task automatic fix_last();
        logic [DW:0] t;
        t = q.pop_back();
        t[DW] = 1'b1;
        q.push_back(t);
    endtask

    // dly<0: never drive a result (timeout expected); else result sampled dly edges after the last beat
    task automatic run(input int mode, input int dly, input logic [RW-1:0] rv, input logic [2:0] eerr);
        int post = -1, k = 0, exp_cyc = 0;
        bit started = 0, pv = 0, pr = 0, got = 0, hs;
        logic tv, tl, rdy, pl = 1'b0;
        logic [DW-1:0] td, pd = '0;
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        for (int c = 0; c < 2000; c++) begin
            @(negedge aclk);
            start = 1'b0;
            if (done) begin got = 1; break; end
            tv = m_tvalid; td = m_tdata; tl = m_tlast;
            if (pv && !pr) begin
                check("stall_valid", tv, 1'b1);
                check("stall_data", {tl, td}, {pl, pd});
            end
            if (q.size() == 0) check("tv_idle", tv, 1'b0);
            rdy = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom_range(0, 1));
            k++;
            m_tready = rdy;
            res_data = (dly >= 0 && post == dly - 1) ? rv : '0;
            if (tv || started) begin started = 1; exp_cyc++; end
            hs = tv && rdy;
            if (hs && q.size() != 0) check("beat", {tl, td}, q.pop_front());
            pv = tv; pr = rdy; pd = td; pl = tl;
            @(posedge aclk);
            if (post >= 0) post++;
            else if (hs && q.size() == 0) post = 0;
        end
        check("done", got, 1'b1);
        check("beats_left", q.size(), 0);
        check("err", err, dly < 0 ? (eerr | 3'b100) : eerr);
        if (dly < 0) begin
            check("timeout_lat", post, TO);
            check("timeout_res", result, '0);
        end else begin
            check("capture_lat", post, dly);
            check("result", result, rv);
            check("cycles", cycles, exp_cyc);
        end
        @(negedge aclk);
        start = 1'b1; res_data = rnd() | 67'h1; ld_valid = 1'b1; ld_data = rnd();
        @(posedge aclk);
        @(negedge aclk);
        start = 1'b0; res_data = '0; ld_valid = 1'b0;
        repeat (2) @(negedge aclk);
        check("hold_idle", {m_tvalid, ld_ready, done}, 3'b001);
        check("hold_result", result, dly < 0 ? '0 : rv);
        if (dly >= 0) check("hold_cycles", cycles, exp_cyc);
    endtask

    initial begin
        logic [RW-1:0] rv;
        do_reset();
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        start = 1'b0;
        repeat (2) @(negedge aclk);
        check("empty_start", {m_tvalid, ld_ready}, 2'b01);

        load_seg(3); load_seg(2);
        run(0, 4, 67'h5, 3'b000);
        check("cycles_9", cycles, 32'd9);

        do_reset();
        load_seg(3); load_seg(2);
        run(1, 2, rnd() | 67'h1, 3'b000);

        do_reset();
        for (int i = 0; i < DEP; i++) load_word(rnd(), i == DEP - 1);
        @(negedge aclk);
        check("full_ready", ld_ready, 1'b0);
        load_word(rnd(), 1'b1);
        @(negedge aclk);
        check("overflow_err", err, 3'b001);
        check("full_count", q.size(), DEP);
        run(0, 1, rnd() | 67'h1, 3'b001);

        do_reset();
        load_seg(2); load_seg(1);
        run(0, -1, '0, 3'b000);

        do_reset();
        for (int i = 0; i < 5; i++) load_seg(1);
        run(2, 3, rnd() | 67'h1, 3'b010);

        do_reset();
        load_seg(4);
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        start = 1'b0; m_tready = 1'b1;
        repeat (2) @(negedge aclk);
        do_reset();
        load_word(rnd(), 1'b0);
        fix_last();
        run(0, 2, rnd() | 67'h1, 3'b000);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int s = 0; s < int'($urandom_range(1, 4)); s++) load_seg(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) begin
                load_word(rnd(), 1'b0);
                fix_last();
            end
            rv = rnd() | 67'h1;
            run(2, int'($urandom_range(1, 6)), rv, 3'b000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
